lvds_word_align: RTL and testbench

LVDS_WORD_ALIGN -- requirements
Module: lvds_word_align

---
 rtl/lvds_word_align.sv | 153 +++++++++++++++
 tb/tb_lvds_word_align.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lvds_word_align.sv
// Word aligner for a deserialized LVDS link: finds the bit rotation of a
// periodic sync byte, verifies it over several frames and tracks lock.
module lvds_word_align #(
    parameter logic [7:0] SYNC_WORD = 8'hBC,
    parameter int         FRAME_LEN = 16,
    parameter int         LOCK_CNT  = 3,
    parameter int         MISS_MAX  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sof,
    output logic       locked,
    output logic [2:0] align_offset,
    output logic [7:0] loss_cnt
);

    localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_C = 4'(MISS_MAX);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [7:0]    prev_q;
    logic [3:0]    match_q, match_d;
    logic [3:0]    miss_q, miss_d;
    logic [2:0]    off_q, off_d;
    logic [7:0]    loss_q, loss_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          sof_q, sof_d;

    logic [15:0]   win;
    logic [7:0]    cand [8];
    logic [7:0]    hit;
    logic          found;
    logic [2:0]    kf;
    logic [2:0]    sel;
    logic          at_sync;
    logic          sync_ok;

    always_comb begin
        win = {prev_q, rx_data};
        for (int k = 0; k < 8; k++) begin
            cand[k] = win[k +: 8];
            hit[k]  = (cand[k] == SYNC_WORD);
        end
        found = |hit;
        kf = 3'd0;
        // Descending scan so the lowest matching rotation wins.
        for (int k = 7; k >= 0; k--) begin
            if (hit[k]) kf = 3'(k);
        end
        at_sync = (pos_q == '0);
        sync_ok = (cand[off_q] == SYNC_WORD);

        state_d = state_q;
        pos_d   = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        match_d = match_q;
        miss_d  = miss_q;
        off_d   = off_q;
        loss_d  = loss_q;
        sel     = off_q;
        sof_d   = 1'b0;

        case (state_q)
            HUNT: begin
                pos_d = '0;
                if (found) begin
                    off_d   = kf;
                    sel     = kf;
                    match_d = 4'd1;
                    pos_d   = PW'(1);
                    state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    sof_d   = (LOCK_CNT == 1);
                end
            end
            VERIFY: begin
                if (at_sync) begin
                    if (sync_ok) begin
                        match_d = match_q + 4'd1;
                        if (match_d >= LOCK_C) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                            sof_d   = 1'b1;
                        end
                    end else begin
                        state_d = HUNT;
                        match_d = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (at_sync) begin
                    if (sync_ok) begin
                        miss_d = 4'd0;
                        sof_d  = 1'b1;
                    end else begin
                        miss_d = miss_q + 4'd1;
                        if (miss_d >= MISS_C) begin
                            state_d = HUNT;
                            miss_d  = 4'd0;
                            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        data_d  = cand[sel];
        valid_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            pos_q   <= '0;
            prev_q  <= 8'd0;
            match_q <= 4'd0;
            miss_q  <= 4'd0;
            off_q   <= 3'd0;
            loss_q  <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            prev_q  <= rx_data;
            match_q <= match_d;
            miss_q  <= miss_d;
            off_q   <= off_d;
            loss_q  <= loss_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
        end
    end

    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign sof          = sof_q;
    assign locked       = (state_q == LOCKED);
    assign align_offset = off_q;
    assign loss_cnt     = loss_q;

endmodule

// File: tb/tb_lvds_word_align.sv
// Directed bench for lvds_word_align: aligned and rotated streams, spurious
// sync, miss handling, loss counting and asynchronous reset.
module tb_lvds_word_align;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sof;
    logic       locked;
    logic [2:0] align_offset;
    logic [7:0] loss_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] s [66];
    logic [7:0] r [65];
    logic [7:0] syn [4];

    lvds_word_align dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .sof          (sof),
        .locked       (locked),
        .align_offset (align_offset),
        .loss_cnt     (loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] d);
        @(negedge clk);
        rx_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, 32'(data_out), 0);
        chk({tag, "_valid"}, 32'(data_valid), 0);
        chk({tag, "_sof"}, 32'(sof), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_off"}, 32'(align_offset), 0);
        chk({tag, "_loss"}, 32'(loss_cnt), 0);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pulse_locked", 32'(locked), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] fw(input int j);
        return (j == 0) ? 8'hBC : 8'(j);
    endfunction

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned stream: lock after third sync, sof every 16 words
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 16; j++) begin
                step(fw(j));
                chk("t1_data", 32'(data_out), 32'(fw(j)));
                chk("t1_valid", 32'(data_valid), 32'(f >= 2));
                chk("t1_locked", 32'(locked), 32'(f >= 2));
                chk("t1_sof", 32'(sof), 32'(f >= 2 && j == 0));
            end
        end
        chk("t1_off", 32'(align_offset), 0);

        // Single miss holds lock; two consecutive misses drop it
        syn[0] = 8'h00;
        syn[1] = 8'hBC;
        syn[2] = 8'h00;
        syn[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step(syn[i]);
            chk("t4_sync_data", 32'(data_out), 32'(syn[i]));
            chk("t4_sync_valid", 32'(data_valid), 32'(i != 3));
            chk("t4_sync_locked", 32'(locked), 32'(i != 3));
            chk("t4_sync_sof", 32'(sof), 32'(syn[i] == 8'hBC));
            chk("t4_loss", 32'(loss_cnt), 32'(i == 3));
            for (int j = 1; j < 16; j++) begin
                step(fw(j));
                chk("t4_word_valid", 32'(data_valid), 32'(i != 3));
            end
        end

        // Relock, then asynchronous reset mid-frame
        for (int f = 0; f < 3; f++) begin
            for (int j = 0; j < 16; j++) step(fw(j));
        end
        chk("t5_locked", 32'(locked), 1);
        for (int j = 1; j < 7; j++) step(fw(j));
        chk("t5_pre_valid", 32'(data_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async");
        @(posedge clk);
        #1;
        chk_zero("t5_held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 7; j < 16; j++) step(fw(j));
        chk("t5_hunt", 32'(locked), 0);
        for (int f = 0; f < 3; f++) begin
            step(fw(0));
            chk("t5_relock", 32'(locked), 32'(f == 2));
            chk("t5_relock_sof", 32'(sof), 32'(f == 2));
            for (int j = 1; j < 16; j++) step(fw(j));
        end

        // Spurious sync at pos 5, corrupted pos-0 sync returns to hunt
        rst_pulse();
        step(8'hBC);
        for (int j = 1; j < 16; j++) begin
            step((j == 5) ? 8'hBC : fw(j));
            chk("t3_locked", 32'(locked), 0);
        end
        step(8'h00);
        chk("t3_fail_locked", 32'(locked), 0);
        chk("t3_fail_valid", 32'(data_valid), 0);
        chk("t3_loss", 32'(loss_cnt), 0);
        for (int f = 0; f < 3; f++) begin
            step(fw(0));
            chk("t3_rehunt", 32'(locked), 32'(f == 2));
            for (int j = 1; j < 16; j++) step(fw(j));
        end

        // Stream rotated so candidate 3 carries the frame
        rst_pulse();
        s[0] = 8'h00;
        s[1] = 8'h00;
        for (int n = 2; n < 66; n++) s[n] = fw((n - 2) % 16);
        for (int n = 0; n < 65; n++) r[n] = {s[n][4:0], s[n+1][7:5]};
        for (int n = 0; n < 65; n++) begin
            step(r[n]);
            if (n == 2) begin
                chk("t2_off", 32'(align_offset), 3);
                chk("t2_first_data", 32'(data_out), 32'h0BC);
            end
            if (n == 33) chk("t2_prelock", 32'(locked), 0);
            if (n >= 34) begin
                chk("t2_data", 32'(data_out), 32'(s[n]));
                chk("t2_valid", 32'(data_valid), 1);
                chk("t2_sof", 32'(sof), 32'((n - 2) % 16 == 0));
            end
        end
        chk("t2_off_hold", 32'(align_offset), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
